// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding the IF/ID register.
// Owns the fetch PC, runs a single-outstanding req/ack handshake to the
// instruction ROM, and buffers returned words in a 2-entry queue whose head
// drives the IF/ID inputs. Redirects flush the queue and retire any in-flight
// request through the KILL state so its data is never presented.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        irom_req_o,
    output logic [31:0] irom_addr_o,
    input  logic        irom_ack_i,
    input  logic [31:0] irom_inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    typedef enum logic {
        FETCH,
        KILL
    } state_t;

    state_t      state, state_nxt;

    logic        req_r, req_nxt;
    logic [31:0] addr_r, addr_nxt;
    logic [31:0] fpc, fpc_nxt;
    logic [1:0]  count, count_nxt;
    logic [31:0] head_pc, head_pc4, head_inst;
    logic [31:0] head_pc_nxt, head_pc4_nxt, head_inst_nxt;
    logic [31:0] skid_pc, skid_inst;
    logic [31:0] skid_pc_nxt, skid_inst_nxt;

    logic        xfer;
    logic        push;
    logic        pop;

    assign xfer = req_r & irom_ack_i;
    assign push = xfer & (state == FETCH) & ~redirect_i;
    assign pop  = (count != 2'd0) & ~stop_i & ~redirect_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a redirect that overtakes an unfinished request parks in KILL
    always_comb begin
        state_nxt = state;
        if (redirect_i) begin
            state_nxt = (req_r & ~irom_ack_i) ? KILL : FETCH;
        end else if ((state == KILL) && xfer) begin
            state_nxt = FETCH;
        end
    end

    // Outputs: request gated by reset, everything else straight from registers
    always_comb begin
        irom_req_o  = req_r & ~rst;
        irom_addr_o = addr_r;
        valid_o     = (count != 2'd0);
        pc_o        = head_pc;
        pc4_o       = head_pc4;
        inst_o      = head_inst;
    end

    // Fetch PC, request and address next values
    always_comb begin
        fpc_nxt = fpc;
        if (redirect_i) begin
            fpc_nxt = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (push) begin
            fpc_nxt = fpc + 32'd4;
        end

        // Request stays up while anything is pending; a fresh one is raised
        // only if the queue will still have room after this edge.
        if (redirect_i || (state == KILL)) begin
            req_nxt = 1'b1;
        end else begin
            req_nxt = (count_nxt < 2'd2);
        end

        // Address is frozen while a request is waiting for its ack, so a
        // redirect in flight cannot disturb the ROM-side handshake.
        addr_nxt = (req_r & ~irom_ack_i) ? addr_r : fpc_nxt;
    end

    // Queue next values: push into head if it will be free, else skid
    always_comb begin
        count_nxt     = count;
        head_pc_nxt   = head_pc;
        head_pc4_nxt  = head_pc4;
        head_inst_nxt = head_inst;
        skid_pc_nxt   = skid_pc;
        skid_inst_nxt = skid_inst;
        if (redirect_i) begin
            count_nxt     = 2'd0;
            head_pc_nxt   = '0;
            head_pc4_nxt  = '0;
            head_inst_nxt = '0;
            skid_pc_nxt   = '0;
            skid_inst_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc_nxt   = addr_r;
                        head_pc4_nxt  = addr_r + 32'd4;
                        head_inst_nxt = irom_inst_i;
                        count_nxt     = 2'd1;
                    end else begin
                        skid_pc_nxt   = addr_r;
                        skid_inst_nxt = irom_inst_i;
                        count_nxt     = 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_pc_nxt   = skid_pc;
                        head_pc4_nxt  = skid_pc + 32'd4;
                        head_inst_nxt = skid_inst;
                        count_nxt     = 2'd1;
                    end else begin
                        head_pc_nxt   = '0;
                        head_pc4_nxt  = '0;
                        head_inst_nxt = '0;
                        count_nxt     = 2'd0;
                    end
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head_pc_nxt   = skid_pc;
                        head_pc4_nxt  = skid_pc + 32'd4;
                        head_inst_nxt = skid_inst;
                        skid_pc_nxt   = addr_r;
                        skid_inst_nxt = irom_inst_i;
                    end else begin
                        head_pc_nxt   = addr_r;
                        head_pc4_nxt  = addr_r + 32'd4;
                        head_inst_nxt = irom_inst_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r     <= 1'b0;
            addr_r    <= RESET_PC;
            fpc       <= RESET_PC;
            count     <= 2'd0;
            head_pc   <= '0;
            head_pc4  <= '0;
            head_inst <= '0;
            skid_pc   <= '0;
            skid_inst <= '0;
        end else begin
            req_r     <= req_nxt;
            addr_r    <= addr_nxt;
            fpc       <= fpc_nxt;
            count     <= count_nxt;
            head_pc   <= head_pc_nxt;
            head_pc4  <= head_pc4_nxt;
            head_inst <= head_inst_nxt;
            skid_pc   <= skid_pc_nxt;
            skid_inst <= skid_inst_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a behavioural ROM whose
// ack latency is set by wait_k; instruction word is addr ^ KEY.
module tb_if_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stop_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        irom_req_o;
    logic [31:0] irom_addr_o;
    logic        irom_ack_i;
    logic [31:0] irom_inst_i;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] inst_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;
    int wait_k = 0;
    int wcnt   = 0;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stop_i        (stop_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .irom_req_o    (irom_req_o),
        .irom_addr_o   (irom_addr_o),
        .irom_ack_i    (irom_ack_i),
        .irom_inst_i   (irom_inst_i),
        .pc_o          (pc_o),
        .pc4_o         (pc4_o),
        .inst_o        (inst_o),
        .valid_o       (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM: ack after wait_k cycles of a raised request
    assign irom_ack_i  = irom_req_o && (wcnt >= wait_k);
    assign irom_inst_i = irom_addr_o ^ KEY;

    always @(posedge clk) begin
        if (irom_req_o && !irom_ack_i) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic v, input logic [31:0] pc);
        check({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
        if (v) begin
            check({tag, ".pc"},   pc_o,   pc);
            check({tag, ".pc4"},  pc4_o,  pc + 32'd4);
            check({tag, ".inst"}, inst_o, pc ^ KEY);
        end else begin
            check({tag, ".inst"}, inst_o, 32'h0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        stop_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        #2;
        // Reset state
        check("rst.req",   {31'b0, irom_req_o}, 32'h0);
        check("rst.addr",  irom_addr_o, 32'h0);
        check("rst.valid", {31'b0, valid_o}, 32'h0);
        check("rst.pc",    pc_o, 32'h0);
        check("rst.pc4",   pc4_o, 32'h0);
        check("rst.inst",  inst_o, 32'h0);
        tick;
        check("rst.req_edge", {31'b0, irom_req_o}, 32'h0);
        rst = 1'b0;

        // Zero-wait stream
        tick;
        check("s.req1",  {31'b0, irom_req_o}, 32'h1);
        check("s.addr1", irom_addr_o, 32'h0);
        expect_head("s.first_empty", 1'b0, 32'h0);
        tick;
        expect_head("s.pc0", 1'b1, 32'h0);
        tick;
        expect_head("s.pc4", 1'b1, 32'h4);
        tick;
        expect_head("s.pc8", 1'b1, 32'h8);
        check("s.addr12", irom_addr_o, 32'hC);

        // Stall three cycles at pc 8: one word enters skid then req drops
        stop_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            expect_head("stall.hold", 1'b1, 32'h8);
            check("stall.req", {31'b0, irom_req_o}, 32'h0);
        end
        stop_i = 1'b0;
        tick;
        expect_head("stall.res12", 1'b1, 32'hC);
        check("stall.req_up", {31'b0, irom_req_o}, 32'h1);
        check("stall.addr16", irom_addr_o, 32'h10);
        tick;
        expect_head("stall.res16", 1'b1, 32'h10);

        // Two wait states: valid every third cycle, address stable under req
        wait_k = 2;
        for (int j = 0; j < 3; j++) begin
            tick;
            expect_head("ws.gap1", 1'b0, 32'h0);
            check("ws.addr1", irom_addr_o, 32'h14 + 32'(4 * j));
            check("ws.req1", {31'b0, irom_req_o}, 32'h1);
            tick;
            expect_head("ws.gap2", 1'b0, 32'h0);
            check("ws.addr2", irom_addr_o, 32'h14 + 32'(4 * j));
            tick;
            expect_head("ws.word", 1'b1, 32'h14 + 32'(4 * j));
        end
        check("ws.pending", irom_addr_o, 32'h20);

        // Redirect overtakes pending 0x20 request
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick;
        redirect_i = 1'b0;
        expect_head("kill.flush", 1'b0, 32'h0);
        check("kill.pc_clr", pc_o, 32'h0);
        check("kill.hold_addr", irom_addr_o, 32'h20);
        check("kill.hold_req", {31'b0, irom_req_o}, 32'h1);
        tick;
        expect_head("kill.wait", 1'b0, 32'h0);
        check("kill.hold_addr2", irom_addr_o, 32'h20);
        tick;
        expect_head("kill.discard", 1'b0, 32'h0);
        check("kill.tgt_addr", irom_addr_o, 32'h100);
        tick;
        expect_head("kill.w1", 1'b0, 32'h0);
        tick;
        expect_head("kill.w2", 1'b0, 32'h0);
        tick;
        expect_head("kill.first", 1'b1, 32'h100);

        // Redirect coinciding with ack and stop
        wait_k        = 0;
        stop_i        = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        tick;
        stop_i     = 1'b0;
        redirect_i = 1'b0;
        expect_head("rds.flush", 1'b0, 32'h0);
        check("rds.addr", irom_addr_o, 32'h200);
        tick;
        expect_head("rds.first", 1'b1, 32'h200);

        // Unaligned redirect near top of address space, then wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick;
        redirect_i = 1'b0;
        check("wrap.addr_top", irom_addr_o, 32'hFFFF_FFFC);
        tick;
        check("wrap.valid", {31'b0, valid_o}, 32'h1);
        check("wrap.pc",    pc_o,   32'hFFFF_FFFC);
        check("wrap.pc4",   pc4_o,  32'h0);
        check("wrap.inst",  inst_o, 32'h5A5A_FFFC);
        check("wrap.addr0", irom_addr_o, 32'h0);
        tick;
        expect_head("wrap.pc0", 1'b1, 32'h0);
        tick;
        expect_head("wrap.pc4v", 1'b1, 32'h4);

        // Fill the queue under stop, then assert reset mid-cycle
        stop_i = 1'b1;
        tick;
        expect_head("full.head", 1'b1, 32'h4);
        check("full.req", {31'b0, irom_req_o}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", {31'b0, valid_o}, 32'h0);
        check("arst.pc",    pc_o,  32'h0);
        check("arst.pc4",   pc4_o, 32'h0);
        check("arst.inst",  inst_o, 32'h0);
        check("arst.req",   {31'b0, irom_req_o}, 32'h0);
        check("arst.addr",  irom_addr_o, 32'h0);
        stop_i = 1'b0;
        tick;
        check("arst.req_hold", {31'b0, irom_req_o}, 32'h0);
        rst = 1'b0;
        tick;
        check("post.req",  {31'b0, irom_req_o}, 32'h1);
        check("post.addr", irom_addr_o, 32'h0);
        tick;
        expect_head("post.first", 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
